crossbar_sched: RTL and testbench

//  Packet scheduler for the 2x2 crossbar (inputs a,b -> outputs c,d); drives its ctr select.
//  ctr=0: straight (a->c, b->d); ctr=1: cross (a->d, b->c).

---
 rtl/crossbar_pkg.sv | 18 +
 rtl/crossbar_beat_cnt.sv | 30 +++
 rtl/crossbar_sched.sv | 117 +++++++++++
 tb/tb_crossbar_sched.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crossbar_pkg.sv
// Shared constants for the 2x2 crossbar scheduler: select encodings, destinations, FSM states.
package crossbar_pkg;

  localparam logic CTR_STRAIGHT = 1'b0;  // a->c, b->d
  localparam logic CTR_CROSS    = 1'b1;  // a->d, b->c

  localparam logic DST_C = 1'b0;
  localparam logic DST_D = 1'b1;

  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_LOCKED = 1'b1;

  // Select value that steers input a (is_b=0) or b (is_b=1) to the requested output.
  function automatic logic need_ctr(input logic is_b, input logic dst);
    return is_b ? ~dst : dst;
  endfunction

endpackage

// File: rtl/crossbar_beat_cnt.sv
// Per-input packet tracker: loads beats-1 on grant, counts accepted beats, drops active on the last.
module crossbar_beat_cnt #(
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [LEN_W-1:0] len,
  input  logic             beat,
  output logic             active
);

  logic [LEN_W-1:0] cnt;

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      active <= 1'b0;
    end else if (load) begin
      cnt    <= len;
      active <= 1'b1;
    end else if (beat && active) begin
      // Counter parks at zero on the last beat instead of wrapping.
      if (cnt == '0) active <= 1'b0;
      else           cnt    <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/crossbar_sched.sv
// Packet scheduler for a 2x2 crossbar: arbitrates requests, holds the select while packets drain.
module crossbar_sched
  import crossbar_pkg::*;
#(
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_req,
  input  logic             b_req,
  input  logic             a_dst,
  input  logic             b_dst,
  input  logic [LEN_W-1:0] a_len,
  input  logic [LEN_W-1:0] b_len,
  input  logic             a_valid,
  input  logic             b_valid,
  input  logic             c_ready,
  input  logic             d_ready,
  output logic             ctr,
  output logic             a_gnt,
  output logic             b_gnt,
  output logic             a_ready,
  output logic             b_ready,
  output logic             c_valid,
  output logic             d_valid,
  output logic             busy
);

  logic state, state_nxt;
  logic prio, prio_nxt;
  logic ctr_nxt;
  logic grant_a, grant_b;
  logic a_busy, b_busy;
  logic wait_a, wait_b, need_a, need_b;

  assign wait_a = a_req & ~a_busy;
  assign wait_b = b_req & ~b_busy;
  assign need_a = need_ctr(1'b0, a_dst);
  assign need_b = need_ctr(1'b1, b_dst);

  // NOTE: every output gets a default first so no path infers a latch.
  always_comb begin
    grant_a   = 1'b0;
    grant_b   = 1'b0;
    ctr_nxt   = ctr;
    prio_nxt  = prio;
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        // Equal needs mean distinct outputs, so one select serves both.
        if (wait_a && wait_b && need_a == need_b) begin
          grant_a = 1'b1;
          grant_b = 1'b1;
          ctr_nxt = need_a;
        end else if (wait_a && (!wait_b || !prio)) begin
          grant_a  = 1'b1;
          ctr_nxt  = need_a;
          prio_nxt = 1'b1;
        end else if (wait_b) begin
          grant_b  = 1'b1;
          ctr_nxt  = need_b;
          prio_nxt = 1'b0;
        end
        if (grant_a || grant_b) state_nxt = ST_LOCKED;
      end
      default: begin
        // A waiter needing the other select blocks joins so it cannot starve.
        grant_a = wait_a && (need_a == ctr) && !(wait_b && need_b != ctr);
        grant_b = wait_b && (need_b == ctr) && !(wait_a && need_a != ctr);
        if (grant_a && !grant_b) prio_nxt = 1'b1;
        if (grant_b && !grant_a) prio_nxt = 1'b0;
        if (!a_busy && !b_busy && !grant_a && !grant_b) state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      prio  <= 1'b0;
      ctr   <= CTR_STRAIGHT;
      a_gnt <= 1'b0;
      b_gnt <= 1'b0;
    end else begin
      state <= state_nxt;
      prio  <= prio_nxt;
      ctr   <= ctr_nxt;
      a_gnt <= grant_a;
      b_gnt <= grant_b;
    end
  end

  crossbar_beat_cnt #(.LEN_W(LEN_W)) u_cnt_a (
    .clk    (clk),
    .rst    (rst),
    .load   (grant_a),
    .len    (a_len),
    .beat   (a_valid & a_ready),
    .active (a_busy)
  );

  crossbar_beat_cnt #(.LEN_W(LEN_W)) u_cnt_b (
    .clk    (clk),
    .rst    (rst),
    .load   (grant_b),
    .len    (b_len),
    .beat   (b_valid & b_ready),
    .active (b_busy)
  );

  assign a_ready = a_busy & ((ctr == CTR_STRAIGHT) ? c_ready : d_ready);
  assign b_ready = b_busy & ((ctr == CTR_STRAIGHT) ? d_ready : c_ready);
  assign c_valid = (ctr == CTR_STRAIGHT) ? (a_valid & a_busy) : (b_valid & b_busy);
  assign d_valid = (ctr == CTR_STRAIGHT) ? (b_valid & b_busy) : (a_valid & a_busy);
  assign busy    = (state == ST_LOCKED);

endmodule

// File: tb/tb_crossbar_sched.sv
// Directed bench for crossbar_sched with a packet-level reference model checked every cycle.
module tb_crossbar_sched;

  localparam int LEN_W = 4;

  logic             clk;
  logic             rst;
  logic             a_req, b_req, a_dst, b_dst;
  logic [LEN_W-1:0] a_len, b_len;
  logic             a_valid, b_valid, c_ready, d_ready;
  logic             ctr, a_gnt, b_gnt, a_ready, b_ready, c_valid, d_valid, busy;

  int n_tests = 0;
  int n_fail  = 0;
  int beats_a = 0;
  int beats_b = 0;

  crossbar_sched #(.LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .b_req(b_req), .a_dst(a_dst), .b_dst(b_dst),
    .a_len(a_len), .b_len(b_len), .a_valid(a_valid), .b_valid(b_valid),
    .c_ready(c_ready), .d_ready(d_ready),
    .ctr(ctr), .a_gnt(a_gnt), .b_gnt(b_gnt), .a_ready(a_ready), .b_ready(b_ready),
    .c_valid(c_valid), .d_valid(d_valid), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic check_n(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model (packet level) ----------------
  typedef struct {
    bit locked;
    bit ctr;
    bit prio;
    bit gnt_a;
    bit gnt_b;
    int rem_a;   // beats still owed by input a
    int rem_b;
  } mstate_t;

  mstate_t m;

  // Output index (0=c, 1=d) that an input reaches under select value c.
  function automatic bit route(input bit is_b, input bit c);
    return is_b ? ~c : c;
  endfunction

  function automatic bit need(input bit is_b, input bit dst);
    return (route(is_b, 1'b0) == dst) ? 1'b0 : 1'b1;
  endfunction

  function automatic bit sink(input bit o);
    return o ? d_ready : c_ready;
  endfunction

  function automatic bit exp_ready(input mstate_t s, input bit is_b);
    int rem = is_b ? s.rem_b : s.rem_a;
    return (rem > 0) && sink(route(is_b, s.ctr));
  endfunction

  function automatic bit exp_valid(input mstate_t s, input bit o);
    return (route(1'b0, s.ctr) == o && a_valid && s.rem_a > 0) ||
           (route(1'b1, s.ctr) == o && b_valid && s.rem_b > 0);
  endfunction

  function automatic mstate_t m_reset();
    mstate_t s;
    s.locked = 0; s.ctr = 0; s.prio = 0; s.gnt_a = 0; s.gnt_b = 0;
    s.rem_a = 0; s.rem_b = 0;
    return s;
  endfunction

  function automatic mstate_t step(input mstate_t s);
    mstate_t n = s;
    bit wa = a_req && s.rem_a == 0;
    bit wb = b_req && s.rem_b == 0;
    bit na = need(1'b0, a_dst);
    bit nb = need(1'b1, b_dst);
    bit ga = 0;
    bit gb = 0;
    bit acc_a = a_valid && exp_ready(s, 1'b0);
    bit acc_b = b_valid && exp_ready(s, 1'b1);
    if (!s.locked) begin
      if (wa && wb && a_dst != b_dst) begin
        ga = 1; gb = 1; n.ctr = na;
      end else if (wa && wb) begin
        if (!s.prio) begin ga = 1; n.ctr = na; n.prio = 1; end
        else         begin gb = 1; n.ctr = nb; n.prio = 0; end
      end else if (wa) begin
        ga = 1; n.ctr = na; n.prio = 1;
      end else if (wb) begin
        gb = 1; n.ctr = nb; n.prio = 0;
      end
      n.locked = ga || gb;
    end else begin
      ga = wa && na == s.ctr && !(wb && nb != s.ctr);
      gb = wb && nb == s.ctr && !(wa && na != s.ctr);
      if (ga && !gb) n.prio = 1;
      if (gb && !ga) n.prio = 0;
      if (s.rem_a == 0 && s.rem_b == 0 && !ga && !gb) n.locked = 0;
    end
    n.rem_a = ga ? int'(a_len) + 1 : s.rem_a - int'(acc_a);
    n.rem_b = gb ? int'(b_len) + 1 : s.rem_b - int'(acc_b);
    n.gnt_a = ga;
    n.gnt_b = gb;
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= m_reset();
    else     m <= step(m);
  end

  always @(negedge clk) begin
    check("cyc_ctr",     ctr,     m.ctr);
    check("cyc_a_gnt",   a_gnt,   m.gnt_a);
    check("cyc_b_gnt",   b_gnt,   m.gnt_b);
    check("cyc_busy",    busy,    m.locked);
    check("cyc_a_ready", a_ready, exp_ready(m, 1'b0));
    check("cyc_b_ready", b_ready, exp_ready(m, 1'b1));
    check("cyc_c_valid", c_valid, exp_valid(m, 1'b0));
    check("cyc_d_valid", d_valid, exp_valid(m, 1'b1));
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
    if (a_valid && a_ready) beats_a++;
    if (b_valid && b_ready) beats_b++;
    @(posedge clk);
    #1;
    if (a_gnt) a_req = 1'b0;
    if (b_gnt) b_req = 1'b0;
  endtask

  task automatic do_reset();
    a_req = 0; b_req = 0; a_dst = 0; b_dst = 0; a_len = '0; b_len = '0;
    a_valid = 1; b_valid = 1; c_ready = 1; d_ready = 1;
    rst = 1;
    tick();
    tick();
    rst = 0;
    beats_a = 0;
    beats_b = 0;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (busy && k < 200) begin
      tick();
      k++;
    end
    check({name, "_idle"}, busy, 1'b0);
  endtask

  task automatic wait_b_gnt(input string name);
    int k = 0;
    while (!b_gnt && k < 50) begin
      tick();
      k++;
    end
    check({name, "_b_gnt"}, b_gnt, 1'b1);
  endtask

  initial begin
    #100000;
    n_fail++;
    $display("FAIL global_timeout at %0t", $time);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    // Reset state, with valids and sink readies already high.
    do_reset();
    check("rst_ctr", ctr, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_a_ready", a_ready, 1'b0);
    check("rst_c_valid", c_valid, 1'b0);
    tick();
    check("nobusy_d_valid", d_valid, 1'b0);

    // 1: a alone, dst=c, 4 beats.
    do_reset();
    a_req = 1; a_dst = 0; a_len = 4'd3;
    tick();
    check("t1_a_gnt", a_gnt, 1'b1);
    check("t1_ctr", ctr, 1'b0);
    check("t1_busy", busy, 1'b1);
    wait_idle("t1");
    check_n("t1_beats_a", beats_a, 4);

    // 2: both want c, a wins on reset priority, b follows with cross select.
    do_reset();
    a_req = 1; a_dst = 0; a_len = 4'd1;
    b_req = 1; b_dst = 0; b_len = 4'd2;
    tick();
    check("t2_a_gnt", a_gnt, 1'b1);
    check("t2_b_nognt", b_gnt, 1'b0);
    check("t2_ctr0", ctr, 1'b0);
    wait_b_gnt("t2");
    check("t2_ctr1", ctr, 1'b1);
    wait_idle("t2");
    check_n("t2_beats_a", beats_a, 2);
    check_n("t2_beats_b", beats_b, 3);

    // 3: a->d and b->c together under cross select.
    do_reset();
    a_req = 1; a_dst = 1; a_len = 4'd2;
    b_req = 1; b_dst = 0; b_len = 4'd2;
    tick();
    check("t3_a_gnt", a_gnt, 1'b1);
    check("t3_b_gnt", b_gnt, 1'b1);
    check("t3_ctr", ctr, 1'b1);
    b_valid = 0;
    #1;
    check("t3_c_valid_lo", c_valid, 1'b0);
    check("t3_d_valid_hi", d_valid, 1'b1);
    b_valid = 1;
    #1;
    check("t3_c_valid_hi", c_valid, 1'b1);
    wait_idle("t3");
    check_n("t3_beats_a", beats_a, 3);
    check_n("t3_beats_b", beats_b, 3);

    // 4: compatible join while a busy; incompatible request waits for drain.
    do_reset();
    a_req = 1; a_dst = 0; a_len = 4'd7;
    tick();
    tick();
    b_req = 1; b_dst = 1; b_len = 4'd0;
    tick();
    check("t4_join_gnt", b_gnt, 1'b1);
    check("t4_join_ctr", ctr, 1'b0);
    tick();
    b_req = 1; b_dst = 0; b_len = 4'd0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t4_blocked", b_gnt, 1'b0);
    end
    wait_b_gnt("t4");
    check("t4_ctr_after", ctr, 1'b1);
    wait_idle("t4");
    check_n("t4_beats_a", beats_a, 8);
    check_n("t4_beats_b", beats_b, 2);

    // 5: sink stall mid-packet.
    do_reset();
    a_req = 1; a_dst = 0; a_len = 4'd5;
    tick();
    tick();
    tick();
    c_ready = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t5_stall_ready", a_ready, 1'b0);
    end
    check_n("t5_beats_held", beats_a, 2);
    c_ready = 1;
    wait_idle("t5");
    check_n("t5_beats_a", beats_a, 6);

    // 6: asynchronous reset mid-packet, then a clean grant.
    do_reset();
    a_req = 1; a_dst = 1; a_len = 4'd7;
    tick();
    check("t6_ctr_cross", ctr, 1'b1);
    tick();
    tick();
    rst = 1;
    #1;
    check("t6_rst_ctr", ctr, 1'b0);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_a_ready", a_ready, 1'b0);
    check("t6_rst_d_valid", d_valid, 1'b0);
    tick();
    rst = 0;
    beats_b = 0;
    b_req = 1; b_dst = 1; b_len = 4'd0;
    tick();
    check("t6_b_gnt", b_gnt, 1'b1);
    check("t6_b_ctr", ctr, 1'b0);
    wait_idle("t6");
    check_n("t6_beats_b", beats_b, 1);

    // 7: maximum length packet, no wrap.
    do_reset();
    b_req = 1; b_dst = 1; b_len = 4'hF;
    tick();
    check("t7_b_gnt", b_gnt, 1'b1);
    wait_idle("t7");
    check_n("t7_beats_b", beats_b, 16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
